// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin over WIDTH bits, one bit per clock, LSB first.
// A single full-subtractor cell walks the operands with a registered borrow and a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             borrow_nxt;
  logic             last;
  logic [WIDTH-1:0] r_nxt;

  // NOTE: every signal driven here is assigned on every pass, so no latch can be inferred.
  always_comb begin
    d          = a_sr[0] ^ b_sr[0] ^ borrow;
    borrow_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
    r_nxt      = {d, r_sr[WIDTH-1:1]};
    last       = (cnt == CW'(WIDTH - 1));
  end

  // NOTE: the shift registers are plain flops, not memory, so they are reset with the rest of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      zero   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register see the pre-edge values of the others.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          borrow <= borrow_nxt;
          r_sr   <= r_nxt;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          if (last) begin
            // r_nxt already holds the final difference bit in its MSB.
            diff  <= r_nxt;
            bout  <= borrow_nxt;
            zero  <= (r_nxt == '0) && !borrow_nxt;
            done  <= 1'b1;
            busy  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: WIDTH=8 directed + random traffic, WIDTH=4 exhaustive.
// Drivers push arithmetic-model expectations; monitors pop and compare when done pulses.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_n8, start8, bin8, busy8, done8, bout8, zero8;
  logic [7:0] a8, b8, diff8;
  logic       rst_n4, start4, bin4, busy4, done4, bout4, zero4;
  logic [3:0] a4, b4, diff4;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n8), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n4), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .zero(zero4)
  );

  typedef struct {
    int diff;
    bit bout;
    bit zero;
    int acc;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  exp_t hold8;
  int   acc8 = -1000;
  int   acc4 = -1000;
  bit   prev_done8 = 1'b0;
  bit   prev_done4 = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Reference: plain integer arithmetic, borrow-out means the true result went negative.
  function automatic exp_t model(input int w, input int a, input int b, input int bin, input int acc);
    exp_t e;
    int   full;
    full   = a - b - bin;
    e.diff = full & ((1 << w) - 1);
    e.bout = (full < 0);
    e.zero = (e.diff == 0) && !e.bout;
    e.acc  = acc;
    return e;
  endfunction

  // Called at a negedge; the start is sampled on edge cyc+1, accepted only once the previous op completed.
  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    if (cyc + 1 >= acc8 + 9) begin
      q8.push_back(model(8, a, b, bin, cyc + 1));
      acc8 = cyc + 1;
    end
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
  endtask

  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic bin);
    a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
    if (cyc + 1 >= acc4 + 5) begin
      q4.push_back(model(4, a, b, bin, cyc + 1));
      acc4 = cyc + 1;
    end
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic wait_done8();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done8) return;
    end
    fail_now("timeout_done8");
  endtask

  task automatic wait_done4();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done4) return;
    end
    fail_now("timeout_done4");
  endtask

  task automatic drain8();
    for (int i = 0; i < 40; i++) begin
      if (q8.size() == 0) return;
      @(negedge clk);
    end
    fail_now("timeout_drain8");
  endtask

  // Monitor for the WIDTH=8 instance: busy window, done/result scoreboard, output hold.
  always @(posedge clk) begin
    #1;
    if (!rst_n8) begin
      prev_done8 = 1'b0;
    end else begin
      check("busy8", 32'(busy8), 32'(cyc >= acc8 && cyc < acc8 + 8));
      if (done8) begin
        if (q8.size() == 0) begin
          fail_now("unexpected_done8");
        end else begin
          hold8 = q8.pop_front();
          check("diff8", 32'(diff8), hold8.diff);
          check("bout8", 32'(bout8), 32'(hold8.bout));
          check("zero8", 32'(zero8), 32'(hold8.zero));
          check("latency8", cyc - hold8.acc, 8);
        end
        if (prev_done8) fail_now("done8_two_cycles");
      end else begin
        check("hold_diff8", 32'(diff8), hold8.diff);
        check("hold_bout8", 32'(bout8), 32'(hold8.bout));
        check("hold_zero8", 32'(zero8), 32'(hold8.zero));
      end
      prev_done8 = done8;
    end
  end

  // Monitor for the WIDTH=4 instance.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst_n4) begin
      prev_done4 = 1'b0;
    end else begin
      if (done4) begin
        if (q4.size() == 0) begin
          fail_now("unexpected_done4");
        end else begin
          e = q4.pop_front();
          check("bout_diff4", {27'd0, bout4, diff4}, {27'd0, e.bout, 4'(e.diff)});
          check("zero4", 32'(zero4), 32'(e.zero));
          check("latency4", cyc - e.acc, 4);
        end
        if (prev_done4) fail_now("done4_two_cycles");
      end
      prev_done4 = done4;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    hold8  = '{diff: 0, bout: 1'b0, zero: 1'b0, acc: 0};
    rst_n8 = 1'b0; rst_n4 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy8", 32'(busy8), 0);
    check("rst_done8", 32'(done8), 0);
    check("rst_diff8", 32'(diff8), 0);
    check("rst_bout8", 32'(bout8), 0);
    check("rst_zero8", 32'(zero8), 0);
    @(negedge clk);
    rst_n8 = 1'b1; rst_n4 = 1'b1;
    @(negedge clk);

    // Plain subtraction, then underflow followed by a start in the done cycle.
    drive8(8'h5A, 8'h3C, 1'b0);
    wait_done8();
    @(negedge clk);
    drive8(8'h00, 8'h01, 1'b0);
    wait_done8();
    drive8(8'hFF, 8'hFF, 1'b1);
    wait_done8();

    // Borrow-in at the MSB boundary, then equal operands giving zero.
    drive8(8'h80, 8'h00, 1'b1);
    wait_done8();
    drive8(8'h33, 8'h33, 1'b0);
    wait_done8();

    // A second start three edges into RUN must be ignored.
    @(negedge clk);
    drive8(8'h12, 8'h34, 1'b0);
    repeat (2) @(negedge clk);
    drive8(8'hAA, 8'h55, 1'b1);
    wait_done8();

    // Reset mid-RUN aborts with no done pulse and cleared outputs.
    @(negedge clk);
    drive8(8'h77, 8'h11, 1'b0);
    repeat (3) @(negedge clk);
    rst_n8 = 1'b0;
    #1;
    check("abort_busy8", 32'(busy8), 0);
    check("abort_done8", 32'(done8), 0);
    check("abort_diff8", 32'(diff8), 0);
    check("abort_bout8", 32'(bout8), 0);
    check("abort_zero8", 32'(zero8), 0);
    q8.delete();
    acc8  = -1000;
    hold8 = '{diff: 0, bout: 1'b0, zero: 1'b0, acc: 0};
    @(negedge clk);
    rst_n8 = 1'b1;
    @(negedge clk);
    drive8(8'hC3, 8'h3C, 1'b1);
    wait_done8();

    // Random traffic with random gaps; starts landing in RUN are ignored by the model too.
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      drive8(8'($urandom), 8'($urandom), 1'($urandom));
    end
    drain8();
    check("q8_drained", q8.size(), 0);

    // WIDTH=4 exhaustive, back-to-back in each done cycle.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int bi = 0; bi < 2; bi++) begin
          drive4(4'(a), 4'(b), 1'(bi));
          wait_done4();
        end
      end
    end
    repeat (2) @(negedge clk);
    check("q4_drained", q4.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised bit-serial subtractor that computes a − b − bin over WIDTH-bit operands, processing one bit per clock, LSB first. It uses a single full-subtractor cell and a registered borrow, with a start/busy/done handshake. It is the multi-bit, sequential successor to the combinational full subtractor in the combinational arithmetic library. It is intended for area-constrained datapaths where WIDTH-cycle latency is acceptable.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on the accepted start edge
- b  input  WIDTH  subtrahend; captured on the accepted start edge
- bin  input  1  borrow-in; captured on the accepted start edge
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse when results update
- diff  output  WIDTH  registered result, a − b − bin mod 2^WIDTH
- bout  output  1  registered borrow-out; 1 when a < b + bin (unsigned)
- zero  output  1  registered; 1 when diff == 0 and bout == 0

## Operation
- FSM states: IDLE, RUN.
- IDLE, with start = 1 at an edge:
  - capture a and b into shift registers a_sr and b_sr
  - set the borrow register to bin
  - clear the bit counter
  - move to RUN and set busy = 1
- IDLE, with start = 0: no change.
- RUN, each edge:
  - d = a_sr[0] ^ b_sr[0] ^ borrow
  - borrow ← (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow)
  - shift d into the MSB of an internal result shift register
  - shift a_sr and b_sr right by one
  - increment the counter
- RUN completion (the edge on which the counter equals WIDTH−1 before incrementing):
  - load diff from the completed internal register, which includes that final d
  - load bout from the final borrow and update zero
  - done ← 1, busy ← 0, state ← IDLE
- Outputs diff, bout and zero change only on the completion edge. They hold the last result across later starts until the next completion.
- done is cleared on the edge after it is set. It never stays high for two consecutive cycles.
- start while busy is ignored. Nothing is queued.
- start in the same cycle that done is high is legal and accepted, because the FSM is already in IDLE. This allows back-to-back operations every WIDTH+1 cycles.
- a, b and bin may change freely after the accepting edge; they are don't-care during RUN.
- The counter width is clog2(WIDTH) bits. No wrap occurs beyond WIDTH−1.

## Timing
- Reset (rst_n low, asynchronous and immediate):
  - state = IDLE
  - busy = 0, done = 0, diff = 0, bout = 0, zero = 0
  - all shift registers, borrow and counter = 0
- Reset asserted mid-RUN aborts the operation. No done pulse is produced. diff, bout and zero read 0.
- Reset release is sampled synchronously. The first start is accepted at the first rising edge after rst_n is high.
- Latency: start accepted at edge E0. busy is high after E0. busy falls, and done, diff, bout and zero update, at edge E_WIDTH.
- WIDTH=8 example: start at E0, result at E8, done high for the cycle E8–E9.
- Throughput: one result per WIDTH+1 cycles at most. busy is low for exactly one cycle between back-to-back operations.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, bin=0 → at E8: diff=0x1E, bout=0, zero=0, done for one cycle, busy high E1..E7.
- WIDTH=8, a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1. Next, a=0xFF, b=0xFF, bin=1 started in the done cycle → diff=0xFF, bout=1, at E17.
- WIDTH=8, a=0x80, b=0x00, bin=1 → diff=0x7F, bout=0. Then a=0x33, b=0x33, bin=0 → diff=0x00, bout=0, zero=1.
- WIDTH=8, start re-pulsed at E3 with different operands during RUN → ignored; result and timing match the first operands only.
- WIDTH=8, rst_n pulled low at E4 mid-RUN → busy, done, diff, bout and zero are 0 immediately. No done pulse appears. A fresh start after release completes normally.
- WIDTH=4, exhaustive over all a, b and bin (512 cases) → {bout, diff} equals (a − b − bin) mod 32 read as 5 bits, with done exactly 4 edges after each accept.
